// File: rtl/fc_relu_stage.sv
`timescale 1ns/1ps
// Purpose : fully-connected layer + ReLU + shift/saturate over a byte-wide memory port.
// Latency : done pulses N_OUT*(3*N_IN+1)+1 cycles after start (N_OUT*(3*N_IN+3)+1 with bias).
// Backpressure: none; the memory answers every read on the next cycle, start is ignored while busy.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-low reset
//   start - begin one pass (sampled only in IDLE)
//   done  - one-cycle completion pulse
//   read  - memory read strobe, addr valid in the same cycle, din returns next cycle
//   addr  - memory address for read/write
//   din   - memory read data
//   dout  - result byte, valid with write
//   write - memory write strobe, one cycle per output neuron
//
// Build option: define FC_BIAS_EN to add a per-neuron signed bias (RDB/BIAS states)
// between the last multiply-accumulate and the write-back.
module fc_relu_stage #(
    parameter int IN_BASE  = 65,
    parameter int N_IN     = 9,
    parameter int W_BASE   = 80,
    parameter int N_OUT    = 4,
    parameter int B_BASE   = 116,
    parameter int OUT_BASE = 120,
    parameter int SHIFT    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       done,
    output logic       read,
    output logic [7:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       write
);

    localparam int IW = $clog2(N_IN + 1);
    localparam int JW = $clog2(N_OUT + 1);

    typedef enum logic [2:0] {IDLE, RDX, RDW, MAC, RDB, BIAS, WR, DONE} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      i_q, i_d;
    logic [JW-1:0]      j_q, j_d;
    logic signed [23:0] acc_q, acc_d;
    logic [7:0]         x_q, x_d;

    logic               read_d, write_d, done_d;
    logic [7:0]         addr_d, dout_d;

    // Activation is unsigned, weight is two's complement: widen x with a zero
    // sign bit so the product is a true signed 9x8 multiply.
    logic signed [16:0] prod;
    logic signed [23:0] acc_sh;

    assign prod   = $signed({1'b0, x_q}) * $signed(din);
    assign acc_sh = acc_d >>> SHIFT;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        acc_d   = acc_q;
        x_d     = x_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RDX;
                    i_d     = '0;
                    j_d     = '0;
                    acc_d   = '0;
                end
            end
            RDX: state_d = RDW;
            RDW: begin
                x_d     = din;
                state_d = MAC;
            end
            MAC: begin
                acc_d = acc_q + {{7{prod[16]}}, prod};
                i_d   = i_q + 1'b1;
                if (i_d == IW'(N_IN)) begin
`ifdef FC_BIAS_EN
                    state_d = RDB;
`else
                    state_d = WR;
`endif
                end else begin
                    state_d = RDX;
                end
            end
            RDB: state_d = BIAS;
            BIAS: begin
                acc_d   = acc_q + {{16{din[7]}}, din};
                state_d = WR;
            end
            WR: begin
                acc_d   = '0;
                i_d     = '0;
                j_d     = j_q + 1'b1;
                state_d = (j_d == JW'(N_OUT)) ? DONE : RDX;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the state being entered so they can be
        // registered and still line up with that state's cycle.
        read_d  = 1'b0;
        write_d = 1'b0;
        done_d  = 1'b0;
        addr_d  = '0;
        dout_d  = '0;
        case (state_d)
            RDX: begin
                read_d = 1'b1;
                addr_d = 8'(IN_BASE + int'(i_d));
            end
            RDW: begin
                read_d = 1'b1;
                addr_d = 8'(W_BASE + int'(j_d) * N_IN + int'(i_d));
            end
            RDB: begin
                read_d = 1'b1;
                addr_d = 8'(B_BASE + int'(j_d));
            end
            WR: begin
                write_d = 1'b1;
                addr_d  = 8'(OUT_BASE + int'(j_d));
                // ReLU, then saturate the shifted value to a byte.
                if (acc_d[23])
                    dout_d = 8'd0;
                else if (acc_sh[23:8] != '0)
                    dout_d = 8'hFF;
                else
                    dout_d = acc_sh[7:0];
            end
            DONE:    done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            read    <= 1'b0;
            write   <= 1'b0;
            done    <= 1'b0;
            addr    <= '0;
            dout    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            read    <= read_d;
            write   <= write_d;
            done    <= done_d;
            addr    <= addr_d;
            dout    <= dout_d;
        end
    end

endmodule

// File: tb/tb_fc_relu_stage.sv
`timescale 1ns/1ps
module tb_fc_relu_stage;

    localparam int IN_BASE  = 65;
    localparam int N_IN     = 9;
    localparam int W_BASE   = 80;
    localparam int N_OUT    = 4;
    localparam int B_BASE   = 116;
    localparam int OUT_BASE = 120;
    localparam int SHIFT    = 4;
`ifdef FC_BIAS_EN
    localparam int PASS_CYC = 121;
`else
    localparam int PASS_CYC = 113;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       done, read, write;
    logic [7:0] addr, dout;
    logic [7:0] din = 8'd0;

    logic [7:0] mem [0:255];   // inputs, weights, biases (written by stimulus only)
    logic [7:0] res [0:255];   // results (written by the DUT only)
    logic       res_clr = 1'b0;

    logic [15:0] sbq[$];       // {addr, data} of each expected write
    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int write_cnt = 0;

    fc_relu_stage #(
        .IN_BASE(IN_BASE), .N_IN(N_IN), .W_BASE(W_BASE), .N_OUT(N_OUT),
        .B_BASE(B_BASE), .OUT_BASE(OUT_BASE), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst(rst_n), .start(start), .done(done), .read(read),
        .addr(addr), .din(din), .dout(dout), .write(write)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Memory: one-cycle read latency, results captured in a separate array.
    always @(posedge clk) begin
        if (read) din <= mem[addr];
        if (res_clr) begin
            for (int k = 0; k < 256; k++) res[k] <= 8'hAA;
        end else if (write) begin
            res[addr] <= dout;
        end
    end

    // Output monitor / scoreboard consumer.
    always @(negedge clk) begin
        logic [15:0] e;
        if (rst_n) begin
            if (done) done_cnt++;
            if (write) begin
                write_cnt++;
                chk("rd_wr_excl", {31'd0, read}, 32'd0);
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL unexpected_write: observed addr %0d data %0d expected no write", addr, dout);
                end else begin
                    e = sbq.pop_front();
                    chk("wr_addr", {24'd0, addr}, {24'd0, e[15:8]});
                    chk("wr_data", {24'd0, dout}, {24'd0, e[7:0]});
                end
            end
`ifndef FC_BIAS_EN
            if (read && addr >= 8'(B_BASE) && addr < 8'(B_BASE + N_OUT)) begin
                tests++;
                fails++;
                $error("FAIL bias_read: observed addr %0d expected no bias access", addr);
            end
`endif
        end
    end

    function automatic logic [7:0] model(input int j);
        longint acc = 0;
        for (int i = 0; i < N_IN; i++)
            acc += longint'(mem[IN_BASE + i]) * longint'($signed(mem[W_BASE + j * N_IN + i]));
`ifdef FC_BIAS_EN
        acc += longint'($signed(mem[B_BASE + j]));
`endif
        if (acc < 0) return 8'd0;
        acc = acc >>> SHIFT;
        if (acc > 255) return 8'd255;
        return 8'(acc);
    endfunction

    task automatic set_mem(input logic [7:0] x, input logic [7:0] w,
                           input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
        for (int i = 0; i < N_IN; i++) mem[IN_BASE + i] = x;
        for (int k = 0; k < N_IN * N_OUT; k++) mem[W_BASE + k] = w;
        mem[B_BASE]     = b0;
        mem[B_BASE + 1] = b1;
        mem[B_BASE + 2] = b2;
        mem[B_BASE + 3] = b3;
    endtask

    task automatic clear_res();
        @(negedge clk) res_clr = 1'b1;
        @(negedge clk) res_clr = 1'b0;
    endtask

    task automatic push_expected();
        for (int j = 0; j < N_OUT; j++) sbq.push_back({8'(OUT_BASE + j), model(j)});
    endtask

    task automatic run_pass(input string tag, input bit extra_start,
                            input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
        int cyc;
        int d0;
        int w0;
        clear_res();
        push_expected();
        d0 = done_cnt;
        w0 = write_cnt;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (extra_start && cyc == 50) start = 1'b1;
            if (cyc == 51) start = 1'b0;
        end
        chk({tag, "_done_cycles"}, cyc, PASS_CYC);
        @(negedge clk);
        chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        repeat (20) @(negedge clk);
        chk({tag, "_queue_empty"}, sbq.size(), 0);
        chk({tag, "_done_count"}, done_cnt - d0, 1);
        chk({tag, "_write_count"}, write_cnt - w0, N_OUT);
        chk({tag, "_out0"}, {24'd0, res[OUT_BASE]},     {24'd0, e0});
        chk({tag, "_out1"}, {24'd0, res[OUT_BASE + 1]}, {24'd0, e1});
        chk({tag, "_out2"}, {24'd0, res[OUT_BASE + 2]}, {24'd0, e2});
        chk({tag, "_out3"}, {24'd0, res[OUT_BASE + 3]}, {24'd0, e3});
    endtask

    initial begin
        int n;
        for (int k = 0; k < 256; k++) mem[k] = 8'(k);

        // Reset state
        #1;
        chk("rst_read",  {31'd0, read},  0);
        chk("rst_write", {31'd0, write}, 0);
        chk("rst_done",  {31'd0, done},  0);
        chk("rst_addr",  {24'd0, addr},  0);
        chk("rst_dout",  {24'd0, dout},  0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef FC_BIAS_EN
        set_mem(8'd1, 8'd16, 8'h00, 8'h00, 8'h00, 8'h00);
`else
        // Non-zero biases must have no effect without the bias option.
        set_mem(8'd1, 8'd16, 8'h80, 8'h10, 8'h7F, 8'hF0);
`endif
        run_pass("ones", 1'b0, 8'd9, 8'd9, 8'd9, 8'd9);

        set_mem(8'd10, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
        run_pass("relu", 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);

        set_mem(8'd255, 8'd127, 8'h00, 8'h00, 8'h00, 8'h00);
        run_pass("sat", 1'b0, 8'd255, 8'd255, 8'd255, 8'd255);

        set_mem(8'd1, 8'd16, 8'h80, 8'h10, 8'h00, 8'hF0);
`ifdef FC_BIAS_EN
        run_pass("bias", 1'b0, 8'd1, 8'd10, 8'd9, 8'd8);
`else
        run_pass("bias", 1'b0, 8'd9, 8'd9, 8'd9, 8'd9);
`endif

        // Reset during the first weight read of neuron 2.
        set_mem(8'd1, 8'd16, 8'h00, 8'h00, 8'h00, 8'h00);
        clear_res();
        push_expected();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!(read === 1'b1 && addr === 8'(W_BASE + 2 * N_IN)) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("mid_rst_reached", {31'd0, n < 3000}, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_read",  {31'd0, read},  0);
        chk("mid_rst_write", {31'd0, write}, 0);
        chk("mid_rst_done",  {31'd0, done},  0);
        chk("mid_rst_addr",  {24'd0, addr},  0);
        chk("mid_rst_dout",  {24'd0, dout},  0);
        chk("mid_rst_pending", sbq.size(), 2);
        sbq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = done_cnt;
        repeat (30) @(negedge clk);
        chk("mid_rst_kept0", {24'd0, res[OUT_BASE]},     9);
        chk("mid_rst_kept1", {24'd0, res[OUT_BASE + 1]}, 9);
        chk("mid_rst_nowr2", {24'd0, res[OUT_BASE + 2]}, 8'hAA);
        chk("mid_rst_nowr3", {24'd0, res[OUT_BASE + 3]}, 8'hAA);
        chk("mid_rst_no_autostart", done_cnt - n, 0);
        run_pass("restart", 1'b0, 8'd9, 8'd9, 8'd9, 8'd9);

        // A second start in the middle of a pass is ignored.
        set_mem(8'd3, 8'd20, 8'h00, 8'h00, 8'h00, 8'h00);
        run_pass("restart_ignored", 1'b1, 8'd33, 8'd33, 8'd33, 8'd33);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fc_relu_stage.md
FC_RELU_STAGE -- requirements
Module: fc_relu_stage

Interface
REQ-001 SHALL have parameter IN_BASE, default 65, memory address of pooled-feature element 0.
REQ-002 SHALL have parameter N_IN, default 9, number of input activations.
REQ-003 SHALL have parameter W_BASE, default 80, address of weight (j,i) = W_BASE + j*N_IN + i.
REQ-004 SHALL have parameter N_OUT, default 4, number of output neurons.
REQ-005 SHALL have parameter B_BASE, default 116, address of bias j = B_BASE + j.
REQ-006 SHALL have parameter OUT_BASE, default 120, address of result j = OUT_BASE + j.
REQ-007 SHALL have parameter SHIFT, default 4, right-shift applied after ReLU.
REQ-008 SHALL have port clk  input  1  sole clock, rising edge.
REQ-009 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-010 SHALL have port start  input  1  begin one pass; sampled only in IDLE.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port read  output  1  memory read strobe.
REQ-013 SHALL have port addr  output  8  memory address.
REQ-014 SHALL have port din  input  8  memory read data, valid the cycle after read.
REQ-015 SHALL have port dout  output  8  memory write data.
REQ-016 SHALL have port write  output  1  memory write strobe, one cycle per result.

Function
REQ-017 SHALL implement states IDLE, RDX, RDW, MAC, RDB, BIAS, WR, DONE.
REQ-018 SHALL leave IDLE for RDX on the edge where start=1; start in any other state is ignored.
REQ-019 SHALL, in RDX: read=1, addr=IN_BASE+i; next RDW.
REQ-020 SHALL, in RDW: capture x=din (unsigned), read=1, addr=W_BASE+j*N_IN+i; next MAC.
REQ-021 SHALL, in MAC: w=din (two's complement), acc += x*w; i++; if i==N_IN go RDB (bias enabled) or WR, else RDX.
REQ-022 SHALL keep acc as a 24-bit signed register, cleared at pass start and after each WR.
REQ-023 SHALL, in WR: write=1, addr=OUT_BASE+j, dout = 0 if acc<0, else min(acc>>>SHIFT, 255); j++, i=0; if j==N_OUT go DONE else RDX.
REQ-024 SHALL, in DONE: done=1 for exactly one cycle, then IDLE.
REQ-025 SHALL drive read, write, done to 0 and addr, dout to 0 in every state not listed as asserting them.
REQ-026 SHALL assert done exactly N_OUT*(3*N_IN+1)+1 cycles after the start edge without bias, N_OUT*(3*N_IN+3)+1 with bias.
REQ-027 SHALL never assert read and write in the same cycle.

Reset
REQ-028 SHALL, while rst=0, force state IDLE, i=j=0, acc=0, and read, write, done, addr, dout to 0 immediately, regardless of clk.
REQ-029 SHALL, on reset mid-pass, abandon the pass with no further write; results already written stay in memory.
REQ-030 SHALL require a new start after rst deasserts.

Configuration
REQ-031 SHALL, with FC_BIAS_EN defined, include RDB (read=1, addr=B_BASE+j) then BIAS (acc += sign-extended din) between the last MAC and WR.
REQ-032 SHALL, without FC_BIAS_EN, omit RDB/BIAS, never address B_BASE, go MAC->WR directly.

Verification
REQ-033 SHALL test: x[0..8]=1, all w=16, no bias, start -> 120..123 = 9; done 113 cycles after start.
REQ-034 SHALL test: x=10, all w=0xFF (-1) -> acc=-90, all outputs 0 (ReLU).
REQ-035 SHALL test: x=255, all w=127 -> acc=291465, outputs saturate to 255.
REQ-036 SHALL test (FC_BIAS_EN): x=1, w=16, bias j0=0x80 (-128), j1=16 -> out0=1 (16>>4), out1=10; done 121 cycles after start.
REQ-037 SHALL test: rst=0 during RDW of j=2 -> outputs 0 at once, addr 122..123 never written; restart -> all four results correct.
REQ-038 SHALL test: start pulsed again mid-pass -> ignored, single done, exactly 4 writes.
